// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive path and the LPC register map.
package uart_pkg;

    // Byte width produced by uart_rx and carried through the receive FIFO.
    localparam int UART_DATA_W = 8;

    // Line status register bit positions that lpc uses to map receive status.
    localparam int LSR_DR = 0;
    localparam int LSR_OE = 1;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: one synchronous write port and one
// asynchronous read port. There is no reset; contents are only meaningful
// where the surrounding pointer logic says so.
module fifo_ram #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    // Store the incoming word at the write address whenever a write is accepted.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer between uart_rx and the LPC interface. Single-cycle receive
// strobes are captured into a first-word-fall-through FIFO so the host can
// drain bytes at bus pace. Provides occupancy, full, data-ready, a sticky
// overrun flag and a registered level trigger.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = UART_DATA_W,
    parameter int RX_TRIG    = 8
) (
    input  logic                  LPC_CLK,
    input  logic                  LPC_RST,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_data_valid,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    input  logic                  ovr_clr,
    output logic                  rx_trig
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] TRIG_CNT  = (DEPTH_LOG2 + 1)'(RX_TRIG);

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_next;
    logic [DATA_W-1:0]     ram_data;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  drop;

    // Flags decode straight from the registered occupancy.
    assign full     = (count == DEPTH_CNT);
    assign rd_valid = (count != '0);

    // A full FIFO still takes a write when the same cycle pops a byte out.
    assign wr_accept = rx_data_valid & (~full | rd_en);
    assign rd_accept = rd_en & rd_valid;
    assign drop      = rx_data_valid & full & ~rd_en;

    // Head byte is forced to zero while empty so stale array contents never leak.
    assign rd_data = rd_valid ? ram_data : '0;

    fifo_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_ram (
        .clk     (LPC_CLK),
        .wr_en   (wr_accept & ~LPC_RST),
        .wr_addr (wr_ptr),
        .wr_data (rx_data),
        .rd_addr (rd_ptr),
        .rd_data (ram_data)
    );

    // Next occupancy: simultaneous push and pop leave the level unchanged.
    always_comb begin
        count_next = count;
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointer, occupancy and trigger state; trigger tracks the next count so it moves with count.
    always_ff @(posedge LPC_CLK) begin
        if (LPC_RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rx_trig <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_next;
            rx_trig <= (count_next >= TRIG_CNT);
        end
    end

    // Sticky overrun: a dropped byte sets it and wins over a clear in the same cycle.
    always_ff @(posedge LPC_CLK) begin
        if (LPC_RST) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. A queue holds the bytes the bench
// expects to be stored; bytes are pushed when a write is driven and popped
// and compared when the bench pops the FIFO.
module tb_uart_rx_fifo;

    localparam int DEPTH   = 16;
    localparam int RX_TRIG = 8;

    logic       LPC_CLK;
    logic       LPC_RST;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       ovr_clr;
    logic       rx_trig;

    logic [7:0] model_q [$];
    logic       model_ovr;
    int         assertCount;
    int         failCount;

    uart_rx_fifo #(
        .DEPTH_LOG2 (4),
        .DATA_W     (8),
        .RX_TRIG    (RX_TRIG)
    ) dut (
        .LPC_CLK       (LPC_CLK),
        .LPC_RST       (LPC_RST),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .full          (full),
        .count         (count),
        .overrun       (overrun),
        .ovr_clr       (ovr_clr),
        .rx_trig       (rx_trig)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        LPC_CLK = 1'b0;
        forever #5 LPC_CLK = ~LPC_CLK;
    end

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Compare every observable output against the bench model.
    task automatic checkState(input string tag);
        logic [7:0] exp_data;
        exp_data = (model_q.size() == 0) ? 8'h00 : model_q[0];
        checkOutput({tag, ".count"},    32'(count),    32'(model_q.size()));
        checkOutput({tag, ".rd_valid"}, 32'(rd_valid), 32'(model_q.size() != 0));
        checkOutput({tag, ".full"},     32'(full),     32'(model_q.size() == DEPTH));
        checkOutput({tag, ".overrun"},  32'(overrun),  32'(model_ovr));
        checkOutput({tag, ".rx_trig"},  32'(rx_trig),  32'(model_q.size() >= RX_TRIG));
        checkOutput({tag, ".rd_data"},  32'(rd_data),  32'(exp_data));
    endtask

    // Drive one cycle of inputs, update the model and check outputs after the edge.
    task automatic applyStimulus(input string tag, input logic valid, input logic [7:0] data,
                                 input logic rd, input logic clr);
        bit m_full;
        bit m_empty;
        @(negedge LPC_CLK);
        rx_data_valid = valid;
        rx_data       = data;
        rd_en         = rd;
        ovr_clr       = clr;
        m_full  = (model_q.size() == DEPTH);
        m_empty = (model_q.size() == 0);
        if (rd && !m_empty) begin
            checkOutput({tag, ".pop"}, 32'(rd_data), 32'(model_q[0]));
            void'(model_q.pop_front());
        end
        if (valid && (!m_full || rd)) begin
            model_q.push_back(data);
        end
        if (valid && m_full && !rd) begin
            model_ovr = 1'b1;
        end else if (clr) begin
            model_ovr = 1'b0;
        end
        @(posedge LPC_CLK);
        #1;
        rx_data_valid = 1'b0;
        rx_data       = 8'h00;
        rd_en         = 1'b0;
        ovr_clr       = 1'b0;
        checkState(tag);
    endtask

    // Hold reset for a number of edges, optionally with a write and pop also asserted.
    task automatic applyReset(input int cycles, input logic valid, input logic rd);
        @(negedge LPC_CLK);
        LPC_RST       = 1'b1;
        rx_data_valid = valid;
        rx_data       = 8'h77;
        rd_en         = rd;
        repeat (cycles) @(posedge LPC_CLK);
        #1;
        LPC_RST       = 1'b0;
        rx_data_valid = 1'b0;
        rx_data       = 8'h00;
        rd_en         = 1'b0;
        model_q.delete();
        model_ovr = 1'b0;
    endtask

    initial begin
        assertCount   = 0;
        failCount     = 0;
        model_ovr     = 1'b0;
        LPC_RST       = 1'b1;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        rd_en         = 1'b0;
        ovr_clr       = 1'b0;

        // Reset then idle
        applyReset(2, 1'b0, 1'b0);
        checkState("reset");
        checkOutput("reset.rd_data_zero", 32'(rd_data), 32'h0);
        checkOutput("reset.count_zero", 32'(count), 32'h0);

        // Single byte in and out
        applyStimulus("single_wr", 1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("single.rd_data", 32'(rd_data), 32'hA5);
        checkOutput("single.count", 32'(count), 32'h1);
        applyStimulus("single_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("single.empty", 32'(rd_valid), 32'h0);

        // Fill, partial drain, wrap and full drain
        for (int i = 0; i < 16; i++) begin
            applyStimulus("fill", 1'b1, 8'(i), 1'b0, 1'b0);
            checkOutput("fill.trig", 32'(rx_trig), 32'(i >= 7));
        end
        checkOutput("fill.full", 32'(full), 32'h1);
        checkOutput("fill.count16", 32'(count), 32'd16);
        for (int i = 0; i < 4; i++) applyStimulus("pop4", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus("wrap_wr", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checkOutput("wrap.order", 32'(rd_data), 32'(8'(i + 4)));
            applyStimulus("wrap_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Overrun: drop, clear, then set wins over clear
        for (int i = 0; i < 16; i++) applyStimulus("ovr_fill", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        applyStimulus("ovr_drop", 1'b1, 8'hEE, 1'b0, 1'b0);
        checkOutput("ovr.set", 32'(overrun), 32'h1);
        checkOutput("ovr.count", 32'(count), 32'd16);
        applyStimulus("ovr_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("ovr.cleared", 32'(overrun), 32'h0);
        applyStimulus("ovr_set_wins", 1'b1, 8'hEF, 1'b0, 1'b1);
        checkOutput("ovr.set_wins", 32'(overrun), 32'h1);
        applyStimulus("ovr_clr2", 1'b0, 8'h00, 1'b0, 1'b1);

        // Full with simultaneous write and pop
        applyStimulus("full_both", 1'b1, 8'h55, 1'b1, 1'b0);
        checkOutput("full_both.count", 32'(count), 32'd16);
        checkOutput("full_both.ovr", 32'(overrun), 32'h0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) checkOutput("full_both.last", 32'(rd_data), 32'h55);
            applyStimulus("full_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Empty with simultaneous write and pop, then pop on empty
        applyStimulus("empty_both", 1'b1, 8'h66, 1'b1, 1'b0);
        checkOutput("empty_both.count", 32'(count), 32'h1);
        checkOutput("empty_both.data", 32'(rd_data), 32'h66);
        applyStimulus("empty_both_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus("rd_on_empty", 1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-operation with concurrent write and pop
        for (int i = 0; i < 16; i++) applyStimulus("mid_fill", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        applyStimulus("mid_drop", 1'b1, 8'hDD, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) applyStimulus("mid_pop", 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("mid.count5", 32'(count), 32'd5);
        checkOutput("mid.ovr", 32'(overrun), 32'h1);
        applyReset(1, 1'b1, 1'b1);
        checkState("mid_reset");
        checkOutput("mid_reset.count", 32'(count), 32'h0);
        checkOutput("mid_reset.ovr", 32'(overrun), 32'h0);
        applyStimulus("post_reset_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer between uart_rx and the lpc bus interface. It absorbs the single-cycle rx_data_valid pulses from uart_rx into a small first-word-fall-through FIFO. The host can then drain received bytes through LPC I/O reads without losing characters during bus latency. It also provides status (data ready, full, level, sticky overrun) and a level-trigger flag for the lpc block's status register.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 entries)
DATA_W, 8, byte width, fixed to match uart_rx output
RX_TRIG, 8, level at or above which rx_trig asserts; legal range 1..2**DEPTH_LOG2

Ports:
LPC_CLK  in  1  system clock, shared with lpc/uart_tx/uart_rx
LPC_RST  in  1  reset; one clock; reset is synchronous and active-high
rx_data  in  DATA_W  byte from uart_rx, qualified by rx_data_valid
rx_data_valid  in  1  one-cycle write strobe from uart_rx
rd_en  in  1  one-cycle pop strobe from lpc (host read of RBR)
rd_data  out  DATA_W  head-of-FIFO byte; valid while rd_valid=1
rd_valid  out  1  FIFO not empty (LSR data-ready)
full  out  1  FIFO holds 2**DEPTH_LOG2 entries
count  out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
overrun  out  1  sticky: a byte was dropped because FIFO was full
ovr_clr  in  1  one-cycle clear of overrun (host read of LSR)
rx_trig  out  1  registered, count >= RX_TRIG

Behaviour:
- All state updates on the rising edge of LPC_CLK. With LPC_RST=1 at an edge: wr_ptr=0, rd_ptr=0, count=0, overrun=0, rx_trig=0. Resulting outputs: rd_valid=0, full=0, rd_data=0 (output forced to 0 when empty).
- Reset mid-operation discards all contents; stored bytes are not recoverable.
- Storage: 2**DEPTH_LOG2 x DATA_W array, no reset on the array. Read is combinational from rd_ptr (FWFT). Pointers are DEPTH_LOG2 bits and wrap naturally from 2**DEPTH_LOG2-1 to 0.
- Write accepted = rx_data_valid & (~full | rd_en). An accepted write stores at wr_ptr, then wr_ptr+1.
- Read accepted = rd_en & rd_valid. An accepted read increments rd_ptr. rd_en while empty is ignored, with no state change.
- Count: +1 on write only, -1 on read only, unchanged on both or neither.
- Latency: a byte written at edge N appears on rd_data, with rd_valid=1, in the cycle after edge N.
- After a pop at edge N, the next byte (or rd_valid=0) is presented after edge N.
- Full + rx_data_valid + no rd_en: byte dropped, contents unchanged, overrun<=1 at the same edge.
- Full + rx_data_valid + rd_en: both accepted, count stays at max, no overrun.
- Empty + rx_data_valid + rd_en: write accepted, read ignored, count becomes 1.
- Overrun: set has priority over ovr_clr in the same cycle. Otherwise ovr_clr=1 clears it. It stays set across pops until cleared.
- rx_trig is registered from the next-state count, so it changes in the same cycle count does.
- full and rd_valid decode combinationally from the registered count: full = count==2**DEPTH_LOG2, rd_valid = count!=0.

Decomposition:
- Shared package uart_pkg: UART_DATA_W=8, and LSR bit positions LSR_DR=0 and LSR_OE=1 used by lpc for mapping rd_valid/overrun.
- One natural sub-module: fifo_ram. It is a simple dual-port array with synchronous write and asynchronous read, parameterised on DEPTH_LOG2/DATA_W.
- Pointer, count and flag logic stays in uart_rx_fifo.
- Integration in device: rx_data/rx_data_valid from uart_rx0 feed this block. lpc0 consumes rd_data/rd_valid/overrun and drives rd_en/ovr_clr.

Test Plan:
- Reset then idle: hold LPC_RST=1 for 2 cycles, release. Outputs must be rd_valid=0, count=0, full=0, overrun=0, rd_data=0x00, rx_trig=0.
- Single byte: pulse rx_data_valid with 0xA5. Next cycle rd_valid=1, rd_data=0xA5, count=1. Pulse rd_en: next cycle rd_valid=0, count=0.
- Fill and wrap: write 0x00..0x0F (16 bytes), then full=1, count=16, rx_trig=1 from the 8th write onward. Pop 4, write 0x10..0x13, pop all. Read order must be 0x04..0x13 with pointer wrap and no loss.
- Overrun: with FIFO full, write 0xEE. Required: dropped, overrun=1, count=16, read order unchanged. Pulse ovr_clr: overrun=0. Repeat the overflow with ovr_clr asserted in the same cycle: overrun=1 (set wins).
- Simultaneous events:
  - Full + write 0x55 + rd_en: count stays 16, no overrun, 0x55 is last out.
  - Empty + write 0x66 + rd_en: count=1, rd_data=0x66.
  - rd_en on empty alone: no change.
- Reset mid-operation: with count=5 and overrun=1, assert LPC_RST together with rx_data_valid and rd_en. After the edge: count=0, overrun=0, rd_valid=0, and the concurrent write is discarded.
